mc_ctrl: RTL and testbench

MC_CTRL -- requirements
Module: mc_ctrl

---
 rtl/mc_ctrl_pkg.sv | 72 +++++++
 rtl/mc_ctrl_decode.sv | 34 +++
 rtl/mc_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_mc_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared constants for the multi-cycle controller.
// Holds FSM state codes, opcode/funct values, instruction-class indices
// and the encodings of the npc_sel, wd_sel, dst_sel and alu_op outputs.
package mc_ctrl_pkg;

    localparam int unsigned OP_W    = 6;
    localparam int unsigned STATE_W = 3;
    localparam int unsigned SEL_W   = 2;
    localparam int unsigned ALU_W   = 3;
    localparam int unsigned CNT_W   = 32;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_e;

    // Primary opcodes (IR[31:26])
    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W-1:0] OP_JAL   = 6'b000011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_BGTZ  = 6'b000111;
    localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
    localparam logic [OP_W-1:0] OP_LUI   = 6'b001111;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;

    // R-type function codes (IR[5:0])
    localparam logic [OP_W-1:0] FN_JR    = 6'b001000;
    localparam logic [OP_W-1:0] FN_ADDU  = 6'b100001;
    localparam logic [OP_W-1:0] FN_SUBU  = 6'b100011;

    // Bit positions of the one-hot instruction class vector
    localparam int unsigned C_ADDU = 0;
    localparam int unsigned C_SUBU = 1;
    localparam int unsigned C_JR   = 2;
    localparam int unsigned C_ORI  = 3;
    localparam int unsigned C_LUI  = 4;
    localparam int unsigned C_LW   = 5;
    localparam int unsigned C_SW   = 6;
    localparam int unsigned C_BEQ  = 7;
    localparam int unsigned C_BGTZ = 8;
    localparam int unsigned C_J    = 9;
    localparam int unsigned C_JAL  = 10;
    localparam int unsigned CLS_W  = 11;

    // npc_sel encodings
    localparam logic [SEL_W-1:0] NPC_PC4  = 2'd0;
    localparam logic [SEL_W-1:0] NPC_BR   = 2'd1;
    localparam logic [SEL_W-1:0] NPC_JUMP = 2'd2;
    localparam logic [SEL_W-1:0] NPC_RS   = 2'd3;

    // wd_sel encodings
    localparam logic [SEL_W-1:0] WD_ALU  = 2'd0;
    localparam logic [SEL_W-1:0] WD_MEM  = 2'd1;
    localparam logic [SEL_W-1:0] WD_LINK = 2'd2;

    // dst_sel encodings
    localparam logic [SEL_W-1:0] DST_RT = 2'd0;
    localparam logic [SEL_W-1:0] DST_RD = 2'd1;
    localparam logic [SEL_W-1:0] DST_RA = 2'd2;

    // alu_op encodings
    localparam logic [ALU_W-1:0] ALU_ADD = 3'd0;
    localparam logic [ALU_W-1:0] ALU_SUB = 3'd1;
    localparam logic [ALU_W-1:0] ALU_OR  = 3'd2;
    localparam logic [ALU_W-1:0] ALU_LUI = 3'd3;

endpackage

// File: rtl/mc_ctrl_decode.sv
// mc_decode: maps op/funct to a one-hot instruction class.
// Ports: op, funct (instruction fields) -> cls (one-hot, all-zero = undecoded).
module mc_decode
    import mc_ctrl_pkg::*;
(
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    output logic [CLS_W-1:0] cls
);

    always_comb begin
        cls = '0;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_ADDU: cls[C_ADDU] = 1'b1;
                    FN_SUBU: cls[C_SUBU] = 1'b1;
                    FN_JR:   cls[C_JR]   = 1'b1;
                    default: cls = '0;
                endcase
            end
            OP_ORI:  cls[C_ORI]  = 1'b1;
            OP_LUI:  cls[C_LUI]  = 1'b1;
            OP_LW:   cls[C_LW]   = 1'b1;
            OP_SW:   cls[C_SW]   = 1'b1;
            OP_BEQ:  cls[C_BEQ]  = 1'b1;
            OP_BGTZ: cls[C_BGTZ] = 1'b1;
            OP_J:    cls[C_J]    = 1'b1;
            OP_JAL:  cls[C_JAL]  = 1'b1;
            default: cls = '0;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS-subset controller (FETCH/DECODE/EXEC/MEM/WB).
// Ports:
//   clk, reset        - clock, synchronous active-high reset
//   op, funct         - instruction fields, stable from DECODE onward
//   zero, gtz         - branch conditions for beq / bgtz
//   pc_we, ir_we, reg_we, mem_we - write enables (combinational)
//   npc_sel, wd_sel, dst_sel, alu_op, ext_op - datapath selects (combinational)
//   state             - registered FSM state
//   illegal           - one-cycle pulse in DECODE for an undecoded instruction
//   retired           - registered count of completed instructions
module mc_ctrl
    import mc_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  op,
    input  logic [5:0]  funct,
    input  logic        zero,
    input  logic        gtz,
    output logic        pc_we,
    output logic        ir_we,
    output logic        reg_we,
    output logic        mem_we,
    output logic [1:0]  npc_sel,
    output logic [1:0]  wd_sel,
    output logic [1:0]  dst_sel,
    output logic [2:0]  alu_op,
    output logic        ext_op,
    output logic [2:0]  state,
    output logic        illegal,
    output logic [31:0] retired
);

    state_e           state_q;
    state_e           state_d;
    logic [CLS_W-1:0] cls;
    logic             retire;
    logic             pc_we_c;
    logic             ir_we_c;
    logic             reg_we_c;
    logic             mem_we_c;
    logic             illegal_c;

    mc_decode u_decode (
        .op    (op),
        .funct (funct),
        .cls   (cls)
    );

    // State register and retirement counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            retired <= '0;
        end else begin
            state_q <= state_d;
            if (retire) begin
                retired <= retired + CNT_W'(1);
            end
        end
    end

    // Next-state and output decode
    always_comb begin
        state_d   = S_FETCH;
        retire    = 1'b0;
        pc_we_c   = 1'b0;
        ir_we_c   = 1'b0;
        reg_we_c  = 1'b0;
        mem_we_c  = 1'b0;
        illegal_c = 1'b0;
        npc_sel   = NPC_PC4;
        wd_sel    = WD_ALU;
        dst_sel   = DST_RT;
        alu_op    = ALU_ADD;
        ext_op    = 1'b0;

        case (state_q)
            S_FETCH: begin
                ir_we_c = 1'b1;
                pc_we_c = 1'b1;
                npc_sel = NPC_PC4;
                state_d = S_DECODE;
            end

            S_DECODE: begin
                if (cls[C_J]) begin
                    pc_we_c = 1'b1;
                    npc_sel = NPC_JUMP;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else if (cls[C_JR]) begin
                    pc_we_c = 1'b1;
                    npc_sel = NPC_RS;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else if (cls[C_JAL]) begin
                    // pc+4 was latched in FETCH, so the link value survives this pc write
                    pc_we_c = 1'b1;
                    npc_sel = NPC_JUMP;
                    state_d = S_WB;
                end else if (cls == '0) begin
                    illegal_c = 1'b1;
                    state_d   = S_FETCH;
                end else begin
                    state_d = S_EXEC;
                end
            end

            S_EXEC: begin
                if (cls[C_ADDU]) begin
                    alu_op  = ALU_ADD;
                    state_d = S_WB;
                end else if (cls[C_SUBU]) begin
                    alu_op  = ALU_SUB;
                    state_d = S_WB;
                end else if (cls[C_ORI]) begin
                    alu_op  = ALU_OR;
                    ext_op  = 1'b0;
                    state_d = S_WB;
                end else if (cls[C_LUI]) begin
                    alu_op  = ALU_LUI;
                    state_d = S_WB;
                end else if (cls[C_LW] || cls[C_SW]) begin
                    alu_op  = ALU_ADD;
                    ext_op  = 1'b1;
                    state_d = S_MEM;
                end else if (cls[C_BEQ]) begin
                    alu_op  = ALU_SUB;
                    pc_we_c = zero;
                    npc_sel = NPC_BR;
                    ext_op  = 1'b1;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else if (cls[C_BGTZ]) begin
                    pc_we_c = gtz;
                    npc_sel = NPC_BR;
                    ext_op  = 1'b1;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_FETCH;
                end
            end

            S_MEM: begin
                if (cls[C_SW]) begin
                    mem_we_c = 1'b1;
                    retire   = 1'b1;
                    state_d  = S_FETCH;
                end else if (cls[C_LW]) begin
                    state_d = S_WB;
                end else begin
                    state_d = S_FETCH;
                end
            end

            S_WB: begin
                reg_we_c = 1'b1;
                retire   = 1'b1;
                state_d  = S_FETCH;
                if (cls[C_ADDU] || cls[C_SUBU]) begin
                    wd_sel  = WD_ALU;
                    dst_sel = DST_RD;
                end else if (cls[C_LW]) begin
                    wd_sel  = WD_MEM;
                    dst_sel = DST_RT;
                end else if (cls[C_JAL]) begin
                    wd_sel  = WD_LINK;
                    dst_sel = DST_RA;
                end else begin
                    wd_sel  = WD_ALU;
                    dst_sel = DST_RT;
                end
            end

            // Unused codes recover to FETCH with everything quiet
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // Reset masks all side effects so a half-finished instruction writes nothing
    assign pc_we   = pc_we_c   & ~reset;
    assign ir_we   = ir_we_c   & ~reset;
    assign reg_we  = reg_we_c  & ~reset;
    assign mem_we  = mem_we_c  & ~reset;
    assign illegal = illegal_c & ~reset;
    assign state   = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: table-driven check of mc_ctrl, one table row per clock cycle,
// plus hand sequences for counter wrap and unused state codes.
module tb_mc_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;
    logic        gtz;
    logic        pc_we, ir_we, reg_we, mem_we;
    logic [1:0]  npc_sel, wd_sel, dst_sel;
    logic [2:0]  alu_op;
    logic        ext_op;
    logic [2:0]  state;
    logic        illegal;
    logic [31:0] retired;

    int total = 0;
    int bad   = 0;

    mc_ctrl dut (
        .clk     (clk),
        .reset   (reset),
        .op      (op),
        .funct   (funct),
        .zero    (zero),
        .gtz     (gtz),
        .pc_we   (pc_we),
        .ir_we   (ir_we),
        .reg_we  (reg_we),
        .mem_we  (mem_we),
        .npc_sel (npc_sel),
        .wd_sel  (wd_sel),
        .dst_sel (dst_sel),
        .alu_op  (alu_op),
        .ext_op  (ext_op),
        .state   (state),
        .illegal (illegal),
        .retired (retired)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        z;
        logic        g;
        logic [2:0]  st;
        logic [3:0]  we;    // {pc_we, ir_we, reg_we, mem_we}
        logic        ill;
        logic [31:0] ret;
        logic [4:0]  m;     // check mask {npc, wd, dst, alu, ext}
        logic [1:0]  npc;
        logic [1:0]  wd;
        logic [1:0]  dst;
        logic [2:0]  alu;
        logic        ext;
    } vec_t;

    vec_t vecs[$];

    localparam logic [5:0] R = 6'b000000, ORI = 6'b001101, LUI = 6'b001111;
    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100;
    localparam logic [5:0] BGTZ = 6'b000111, J = 6'b000010, JAL = 6'b000011;
    localparam logic [5:0] BAD = 6'b111111;
    localparam logic [5:0] ADDU = 6'b100001, SUBU = 6'b100011, JR = 6'b001000;

    function automatic vec_t v(logic rst, logic [5:0] o, logic [5:0] f, logic z, logic g,
                               logic [2:0] st, logic [3:0] we, logic ill, logic [31:0] ret,
                               logic [4:0] m, logic [1:0] npc, logic [1:0] wd,
                               logic [1:0] dst, logic [2:0] alu, logic ext);
        vec_t r;
        r.rst = rst; r.op = o; r.fn = f; r.z = z; r.g = g;
        r.st = st; r.we = we; r.ill = ill; r.ret = ret;
        r.m = m; r.npc = npc; r.wd = wd; r.dst = dst; r.alu = alu; r.ext = ext;
        return r;
    endfunction

    task automatic chk(input string name, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL row %0d %s: got %0h want %0h", row, name, act, exp);
        end
    endtask

    task automatic check_core(input int row, input logic [2:0] st, input logic [3:0] we,
                              input logic ill, input logic [31:0] ret);
        chk("state", row, 32'(state), 32'(st));
        chk("we{pc,ir,reg,mem}", row, 32'({pc_we, ir_we, reg_we, mem_we}), 32'(we));
        chk("illegal", row, 32'(illegal), 32'(ill));
        chk("retired", row, retired, ret);
    endtask

    initial begin
        // rst op fn z g | st we ill ret | mask npc wd dst alu ext
        // reset held while in FETCH: enables masked
        vecs.push_back(v(1, ORI, R, 0, 0, 0, 4'b0000, 0, 0, 5'b00000, 0, 0, 0, 0, 0));
        // ori: 0,1,2,4
        vecs.push_back(v(0, ORI, R, 0, 0, 0, 4'b1100, 0, 0, 5'b10000, 0, 0, 0, 0, 0));
        vecs.push_back(v(0, ORI, R, 0, 0, 1, 4'b0000, 0, 0, 5'b00000, 0, 0, 0, 0, 0));
        vecs.push_back(v(0, ORI, R, 0, 0, 2, 4'b0000, 0, 0, 5'b00011, 0, 0, 0, 2, 0));
        vecs.push_back(v(0, ORI, R, 0, 0, 4, 4'b0010, 0, 0, 5'b01100, 0, 0, 0, 0, 0));
        // lw: 0,1,2,3,4
        vecs.push_back(v(0, LW, R, 0, 0, 0, 4'b1100, 0, 1, 5'b10000, 0, 0, 0, 0, 0));
        vecs.push_back(v(0, LW, R, 0, 0, 1, 4'b0000, 0, 1, 5'b00000, 0, 0, 0, 0, 0));
        vecs.push_back(v(0, LW, R, 0, 0, 2, 4'b0000, 0, 1, 5'b00011, 0, 0, 0, 0, 1));
        vecs.push_back(v(0, LW, R, 0, 0, 3, 4'b0000, 0, 1, 5'b00000, 0, 0, 0, 0, 0));
        vecs.push_back(v(0, LW, R, 0, 0, 4, 4'b0010, 0, 1, 5'b01100, 0, 1, 0, 0, 0));
        // sw: mem_we only in MEM
        vecs.push_back(v(0, SW, R, 0, 0, 0, 4'b1100, 0, 2, 5'b00000, 0, 0, 0, 0, 0));
        vecs.push_back(v(0, SW, R, 0, 0, 1, 4'b0000, 0, 2, 5'b00000, 0, 0, 0, 0, 0));
        vecs.push_back(v(0, SW, R, 0, 0, 2, 4'b0000, 0, 2, 5'b00011, 0, 0, 0, 0, 1));
        vecs.push_back(v(0, SW, R, 0, 0, 3, 4'b0001, 0, 2, 5'b00000, 0, 0, 0, 0, 0));
        // addu
        vecs.push_back(v(0, R, ADDU, 0, 0, 0, 4'b1100, 0, 3, 5'b00000, 0, 0, 0, 0, 0));
        vecs.push_back(v(0, R, ADDU, 0, 0, 1, 4'b0000, 0, 3, 5'b00000, 0, 0, 0, 0, 0));
        vecs.push_back(v(0, R, ADDU, 0, 0, 2, 4'b0000, 0, 3, 5'b00010, 0, 0, 0, 0, 0));
        vecs.push_back(v(0, R, ADDU, 0, 0, 4, 4'b0010, 0, 3, 5'b01100, 0, 0, 1, 0, 0));
        // subu
        vecs.push_back(v(0, R, SUBU, 0, 0, 0, 4'b1100, 0, 4, 5'b00000, 0, 0, 0, 0, 0));
        vecs.push_back(v(0, R, SUBU, 0, 0, 1, 4'b0000, 0, 4, 5'b00000, 0, 0, 0, 0, 0));
        vecs.push_back(v(0, R, SUBU, 0, 0, 2, 4'b0000, 0, 4, 5'b00010, 0, 0, 0, 1, 0));
        vecs.push_back(v(0, R, SUBU, 0, 0, 4, 4'b0010, 0, 4, 5'b01100, 0, 0, 1, 0, 0));
        // lui
        vecs.push_back(v(0, LUI, R, 0, 0, 0, 4'b1100, 0, 5, 5'b00000, 0, 0, 0, 0, 0));
        vecs.push_back(v(0, LUI, R, 0, 0, 1, 4'b0000, 0, 5, 5'b00000, 0, 0, 0, 0, 0));
        vecs.push_back(v(0, LUI, R, 0, 0, 2, 4'b0000, 0, 5, 5'b00010, 0, 0, 0, 3, 0));
        vecs.push_back(v(0, LUI, R, 0, 0, 4, 4'b0010, 0, 5, 5'b01100, 0, 0, 0, 0, 0));
        // beq taken
        vecs.push_back(v(0, BEQ, R, 1, 0, 0, 4'b1100, 0, 6, 5'b00000, 0, 0, 0, 0, 0));
        vecs.push_back(v(0, BEQ, R, 1, 0, 1, 4'b0000, 0, 6, 5'b00000, 0, 0, 0, 0, 0));
        vecs.push_back(v(0, BEQ, R, 1, 0, 2, 4'b1000, 0, 6, 5'b10011, 1, 0, 0, 1, 1));
        // beq not taken, still retires
        vecs.push_back(v(0, BEQ, R, 0, 1, 0, 4'b1100, 0, 7, 5'b00000, 0, 0, 0, 0, 0));
        vecs.push_back(v(0, BEQ, R, 0, 1, 1, 4'b0000, 0, 7, 5'b00000, 0, 0, 0, 0, 0));
        vecs.push_back(v(0, BEQ, R, 0, 1, 2, 4'b0000, 0, 7, 5'b10011, 1, 0, 0, 1, 1));
        // bgtz taken
        vecs.push_back(v(0, BGTZ, R, 0, 1, 0, 4'b1100, 0, 8, 5'b00000, 0, 0, 0, 0, 0));
        vecs.push_back(v(0, BGTZ, R, 0, 1, 1, 4'b0000, 0, 8, 5'b00000, 0, 0, 0, 0, 0));
        vecs.push_back(v(0, BGTZ, R, 0, 1, 2, 4'b1000, 0, 8, 5'b10001, 1, 0, 0, 0, 1));
        // bgtz not taken
        vecs.push_back(v(0, BGTZ, R, 1, 0, 0, 4'b1100, 0, 9, 5'b00000, 0, 0, 0, 0, 0));
        vecs.push_back(v(0, BGTZ, R, 1, 0, 1, 4'b0000, 0, 9, 5'b00000, 0, 0, 0, 0, 0));
        vecs.push_back(v(0, BGTZ, R, 1, 0, 2, 4'b0000, 0, 9, 5'b10001, 1, 0, 0, 0, 1));
        // j
        vecs.push_back(v(0, J, R, 0, 0, 0, 4'b1100, 0, 10, 5'b00000, 0, 0, 0, 0, 0));
        vecs.push_back(v(0, J, R, 0, 0, 1, 4'b1000, 0, 10, 5'b10000, 2, 0, 0, 0, 0));
        // jr
        vecs.push_back(v(0, R, JR, 0, 0, 0, 4'b1100, 0, 11, 5'b00000, 0, 0, 0, 0, 0));
        vecs.push_back(v(0, R, JR, 0, 0, 1, 4'b1000, 0, 11, 5'b10000, 3, 0, 0, 0, 0));
        // jal
        vecs.push_back(v(0, JAL, R, 0, 0, 0, 4'b1100, 0, 12, 5'b00000, 0, 0, 0, 0, 0));
        vecs.push_back(v(0, JAL, R, 0, 0, 1, 4'b1000, 0, 12, 5'b10000, 2, 0, 0, 0, 0));
        vecs.push_back(v(0, JAL, R, 0, 0, 4, 4'b0010, 0, 12, 5'b01100, 0, 2, 2, 0, 0));
        // illegal opcode: pulse, no retire
        vecs.push_back(v(0, BAD, R, 0, 0, 0, 4'b1100, 0, 13, 5'b00000, 0, 0, 0, 0, 0));
        vecs.push_back(v(0, BAD, R, 0, 0, 1, 4'b0000, 1, 13, 5'b00000, 0, 0, 0, 0, 0));
        // illegal R-type funct
        vecs.push_back(v(0, R, 6'b000000, 0, 0, 0, 4'b1100, 0, 13, 5'b00000, 0, 0, 0, 0, 0));
        vecs.push_back(v(0, R, 6'b000000, 0, 0, 1, 4'b0000, 1, 13, 5'b00000, 0, 0, 0, 0, 0));
        // ori with reset asserted in WB: reg_we suppressed, counter cleared
        vecs.push_back(v(0, ORI, R, 0, 0, 0, 4'b1100, 0, 13, 5'b00000, 0, 0, 0, 0, 0));
        vecs.push_back(v(0, ORI, R, 0, 0, 1, 4'b0000, 0, 13, 5'b00000, 0, 0, 0, 0, 0));
        vecs.push_back(v(0, ORI, R, 0, 0, 2, 4'b0000, 0, 13, 5'b00000, 0, 0, 0, 0, 0));
        vecs.push_back(v(1, ORI, R, 0, 0, 4, 4'b0000, 0, 13, 5'b00000, 0, 0, 0, 0, 0));
        // lw with reset asserted in MEM: FETCH next, retired 0
        vecs.push_back(v(0, LW, R, 0, 0, 0, 4'b1100, 0, 0, 5'b00000, 0, 0, 0, 0, 0));
        vecs.push_back(v(0, LW, R, 0, 0, 1, 4'b0000, 0, 0, 5'b00000, 0, 0, 0, 0, 0));
        vecs.push_back(v(0, LW, R, 0, 0, 2, 4'b0000, 0, 0, 5'b00000, 0, 0, 0, 0, 0));
        vecs.push_back(v(1, LW, R, 0, 0, 3, 4'b0000, 0, 0, 5'b00000, 0, 0, 0, 0, 0));
        vecs.push_back(v(0, LW, R, 0, 0, 0, 4'b1100, 0, 0, 5'b00000, 0, 0, 0, 0, 0));

        reset = 1'b1; op = ORI; funct = R; zero = 1'b0; gtz = 1'b0;
        @(posedge clk);

        foreach (vecs[i]) begin
            @(negedge clk);
            reset = vecs[i].rst;
            op    = vecs[i].op;
            funct = vecs[i].fn;
            zero  = vecs[i].z;
            gtz   = vecs[i].g;
            #1;
            check_core(i, vecs[i].st, vecs[i].we, vecs[i].ill, vecs[i].ret);
            if (vecs[i].m[4]) chk("npc_sel", i, 32'(npc_sel), 32'(vecs[i].npc));
            if (vecs[i].m[3]) chk("wd_sel",  i, 32'(wd_sel),  32'(vecs[i].wd));
            if (vecs[i].m[2]) chk("dst_sel", i, 32'(dst_sel), 32'(vecs[i].dst));
            if (vecs[i].m[1]) chk("alu_op",  i, 32'(alu_op),  32'(vecs[i].alu));
            if (vecs[i].m[0]) chk("ext_op",  i, 32'(ext_op),  32'(vecs[i].ext));
        end

        // Counter wrap: preset to all-ones in DECODE of a j, which retires there
        @(negedge clk);
        op = J; funct = R;
        dut.retired = 32'hFFFF_FFFF;
        #1;
        check_core(100, 3'd1, 4'b1000, 1'b0, 32'hFFFF_FFFF);
        @(negedge clk);
        #1;
        check_core(101, 3'd0, 4'b1100, 1'b0, 32'h0000_0000);

        // Unused state code: quiet for one cycle, then FETCH with no retirement
        @(negedge clk);
        dut.state_q = mc_ctrl_pkg::state_e'(3'd6);
        #1;
        check_core(102, 3'd6, 4'b0000, 1'b0, 32'h0000_0000);
        @(negedge clk);
        #1;
        check_core(103, 3'd0, 4'b1100, 1'b0, 32'h0000_0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
